// File: rtl/proc_trace_buffer_if.sv
// proc_trace_buffer_if: val/rdy record stream carrying one commit-trace entry (PC, instruction, data).
interface proc_trace_buffer_if;
    logic        val;
    logic        rdy;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] data;
    modport master (output val, addr, inst, data, input rdy);
    modport slave  (input val, addr, inst, data, output rdy);
endinterface

// File: rtl/proc_trace_buffer.sv
// proc_trace_buffer: non-stalling FIFO for the commit trace; full-buffer entries are dropped and counted.
module proc_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    proc_trace_buffer_if.slave       trc,
    proc_trace_buffer_if.master      deq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CW-1:0]            drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    logic [95:0]   mem [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [NW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          deq_fire, full, enq_ok, drop;

    always_comb begin
        deq_fire = (count_q != '0) && deq.rdy;
        full     = count_q == NW'(DEPTH);
        enq_ok   = trc.val && (!full || deq_fire);
        drop     = trc.val && !enq_ok;
        wp_d     = clr ? '0 : wp_q + AW'(enq_ok);
        rp_d     = clr ? '0 : rp_q + AW'(deq_fire);
        count_d  = clr ? '0 : count_q + NW'(enq_ok) - NW'(deq_fire);
        ovf_d    = clr ? 1'b0 : ovf_q | drop;
        drop_d   = clr ? '0 : (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (enq_ok && !clr) mem[wp_q] <= {trc.addr, trc.inst, trc.data};
    end

    assign trc.rdy  = 1'b1;
    assign deq.val  = count_q != '0;
    assign deq.addr = mem[rp_q][95:64];
    assign deq.inst = mem[rp_q][63:32];
    assign deq.data = mem[rp_q][31:0];
    assign count    = count_q;
    assign overflow = ovf_q;
    assign drop_cnt = drop_q;
endmodule

// File: tb/tb_proc_trace_buffer.sv
// tb_proc_trace_buffer: directed checks of ordering, overflow, wrap, saturation, clear and async reset.
module tb_proc_trace_buffer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] count;
    logic       overflow;
    logic [3:0] drop_cnt;
    int         errors = 0;
    int         checks = 0;

    proc_trace_buffer_if trc ();
    proc_trace_buffer_if deq ();

    proc_trace_buffer #(.DEPTH(8), .CW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .trc      (trc),
        .deq      (deq),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a);
        trc.val  = v;
        trc.addr = a;
        trc.inst = ~a;
        trc.data = a + 32'h1;
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + 32'(4 * i));
            step();
        end
        drive(1'b0, 32'h0);
    endtask

    initial begin
        drive(1'b0, 32'h0);
        deq.rdy = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_val", 32'(deq.val), 32'd0);

        deq.rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(4 * i));
            trc.data = 32'(i + 1);
            chk("pass_empty_val", 32'(deq.val), i == 0 ? 32'd0 : 32'd1);
            step();
            chk("pass_count", 32'(count), 32'd1);
            chk("pass_addr", deq.addr, 32'(4 * i));
            chk("pass_data", deq.data, 32'(i + 1));
        end
        drive(1'b0, 32'h0);
        step();
        chk("pass_drained", 32'(count), 32'd0);

        deq.rdy = 1'b0;
        fill(10, 32'h0);
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_ovf", 32'(overflow), 32'd1);
        chk("fill_drop", 32'(drop_cnt), 32'd2);
        chk("fill_inst", deq.inst, ~32'h0);
        deq.rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_addr", deq.addr, 32'(4 * i));
            step();
        end
        chk("drain_empty", 32'(deq.val), 32'd0);

        deq.rdy = 1'b0;
        fill(8, 32'h40);
        deq.rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h60 + 32'(4 * i));
            step();
            chk("full_rw_count", 32'(count), 32'd8);
        end
        drive(1'b0, 32'h0);
        chk("full_rw_drop", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_addr", deq.addr, 32'h50 + 32'(4 * i));
            step();
        end
        chk("wrap_empty", 32'(count), 32'd0);

        deq.rdy = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_drop", 32'(drop_cnt), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        fill(8, 32'h200);
        fill(14, 32'h300);
        chk("sat_14", 32'(drop_cnt), 32'd14);
        fill(1, 32'h400);
        chk("sat_15", 32'(drop_cnt), 32'hF);
        fill(5, 32'h500);
        chk("sat_hold", 32'(drop_cnt), 32'hF);
        chk("sat_ovf", 32'(overflow), 32'd1);
        chk("sat_head", deq.addr, 32'h200);

        clr = 1'b1;
        step();
        clr = 1'b0;
        fill(5, 32'h600);
        chk("pre_clr_count", 32'(count), 32'd5);
        clr = 1'b1;
        drive(1'b1, 32'hDEAD);
        step();
        clr = 1'b0;
        drive(1'b0, 32'h0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_val", 32'(deq.val), 32'd0);
        chk("clr_drop2", 32'(drop_cnt), 32'd0);
        fill(1, 32'h100);
        chk("post_clr_val", 32'(deq.val), 32'd1);
        chk("post_clr_addr", deq.addr, 32'h100);
        chk("post_clr_count", 32'(count), 32'd1);

        clr = 1'b1;
        step();
        clr = 1'b0;
        fill(9, 32'h700);
        deq.rdy = 1'b1;
        for (int i = 0; i < 5; i++) step();
        deq.rdy = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_ovf", 32'(overflow), 32'd1);
        chk("pre_rst_head", deq.addr, 32'h714);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_val", 32'(deq.val), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        step();
        rst = 1'b0;
        fill(1, 32'h800);
        chk("post_rst_addr", deq.addr, 32'h800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/proc_trace_buffer.md
# proc_trace_buffer

Captures the processor's per-instruction commit trace (`trace_val`, `trace_addr`, `trace_inst`, `trace_data`) into a small FIFO and presents it to a downstream consumer (UART dumper, on-chip checker) over a val/rdy stream. The processor trace port has no backpressure, so the buffer never stalls the core. On overflow it drops entries and counts the drops.

## Interface

Parameters:
- `DEPTH`, 8: number of entries; power of two, from 2 to 64.
- `CW`, 16: width of the drop counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous clear of the FIFO contents and the drop statistics.
- `trace_val`  in  1  one instruction commits this cycle.
- `trace_addr`  in  32  PC of the committed instruction.
- `trace_inst`  in  32  instruction word.
- `trace_data`  in  32  writeback or CSR data (may be X for non-writing instructions).
- `deq_val`  out  1  head entry is valid.
- `deq_rdy`  in  1  consumer accepts the head entry.
- `deq_addr`  out  32  head entry field.
- `deq_inst`  out  32  head entry field.
- `deq_data`  out  32  head entry field.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `overflow`  out  1  sticky; set on the first dropped entry.
- `drop_cnt`  out  CW  dropped entries; saturates at all-ones.

## Operation

- Storage is a circular buffer of DEPTH × 96-bit entries, with a write pointer `wp` and a read pointer `rp` of $clog2(DEPTH) bits each. Both pointers wrap modulo DEPTH.
- Occupancy is `count`, which runs from 0 to DEPTH.
- Event definitions:
  - enq: `trace_val` = 1.
  - deq: `deq_val && deq_rdy`.
  - `deq_val` = (`count` != 0).
- Enqueue is accepted when `count` < DEPTH, or when `count` = DEPTH and deq fires in the same cycle, since the slot freed by deq is reused.
- Otherwise, an enq while full is a drop:
  - the entry is discarded;
  - `overflow` is set to 1;
  - `drop_cnt` increments, saturating at 2^CW-1.
- Count update:
  - enq accepted and no deq: `count` +1;
  - deq and no accepted enq: `count` -1;
  - both: `count` unchanged, and both pointers advance.
- Fields are stored verbatim, including X bits in `trace_data`; no transformation is applied.
- `deq_addr`, `deq_inst` and `deq_data` always reflect the entry at `rp`. They are don't-care when `deq_val` = 0.
- `clr`, when asserted with `rst` low:
  - takes effect at the next edge;
  - sets `wp`, `rp`, `count`, `overflow` and `drop_cnt` to 0;
  - discards any same-cycle enq or deq (the entry is not counted as a drop).
- `rst` asserted at any time:
  - immediately forces `count` = 0, `deq_val` = 0, `overflow` = 0, `drop_cnt` = 0, and `wp` = `rp` = 0;
  - does not reset the storage array;
  - takes priority over `clr`.
- State summary: EMPTY (`count` = 0), PARTIAL, FULL (`count` = DEPTH). These are derived from `count`; no separate FSM register exists.

## Timing

- Latency: an entry enqueued at edge N is visible with `deq_val` = 1 after edge N. There is no combinational bypass from `trace_*` to `deq_*`, so an empty buffer shows `deq_val` = 0 in the same cycle as enq.
- Throughput: one enq and one deq per cycle sustained, with no bubbles at any occupancy, including FULL.
- `deq_val` never depends combinationally on `deq_rdy`. Once asserted, `deq_val` and the head fields hold stable until deq fires, or until `clr`/`rst`.
- `count`, `overflow` and `drop_cnt` are registered and update at the same edge as the event that changes them.
- Wrap-around: after DEPTH accepted enqueues, `wp` returns to 0. Ordering is strictly FIFO across the wrap.
- Drop decision uses `count` and deq as sampled at the same edge. A deq and a full-enq in the same cycle is never a drop.

## Test plan

- Reset values: assert `rst` mid-simulation with 3 entries queued → `deq_val` = 0, `count` = 0, `overflow` = 0 and `drop_cnt` = 0 asynchronously, before the next edge.
- Ordered pass-through: with `deq_rdy` = 1 and DEPTH = 8, push 3 trace records (addr 0x000, 0x004, 0x008; data 0x01, 0x02, 0x03) on consecutive cycles.
  - Each appears one cycle after its enqueue, in order.
  - `count` never exceeds 1.
- Fill and overflow: with `deq_rdy` = 0, push 10 records (addr 0x00 to 0x24).
  - `count` = 8 and `overflow` = 1; `drop_cnt` = 2.
  - Draining yields addr 0x00 to 0x1C.
- Full with simultaneous enq and deq: at `count` = 8, assert `trace_val` and `deq_rdy` for 4 cycles.
  - `count` stays 8 and `drop_cnt` is unchanged.
  - Final drain order confirms wrap-around.
- Saturation: with CW = 4 and a full buffer, drop 20 entries → `drop_cnt` = 0xF; `overflow` = 1.
- Clear priority: assert `clr` together with `trace_val` while `count` = 5.
  - Next cycle: `count` = 0, `deq_val` = 0 and `drop_cnt` = 0.
  - A subsequent push of addr 0x100 dequeues as the first entry.
